// File: rtl/id_queue_rsp_merge.sv
// id_queue_rsp_merge
//
// Consumer of the id_queue output port. Each incoming response is tagged with
// an ID. The block looks up the oldest id_queue entry with that ID, pops it,
// and merges the stored metadata with the response. The merged record goes
// into a 2-entry output buffer. The mst_* stream is driven straight from the
// buffer head register, so the output has exactly one cycle of latency and no
// combinational path from rsp_* to mst_*.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   rsp_id_i, rsp_i         response ID and payload (valid/ready upstream)
//   rsp_valid_i/rsp_ready_o upstream handshake; ready equals lookup fire
//   q_id_o, q_pop_o         lookup ID to the id_queue; pop is always requested
//   q_req_o, q_gnt_i        lookup request / grant (data returned same cycle)
//   q_data_i                element found by the lookup
//   q_data_valid_i          element exists; only meaningful while q_gnt_i
//   mst_id_o, mst_rsp_o     merged ID and response payload
//   mst_meta_o              popped metadata, '0 when the lookup missed
//   mst_miss_o              no queue entry existed for the ID
//   mst_valid_o/mst_ready_i downstream handshake
//   miss_cnt_o              saturating count of lookup misses

module id_queue_rsp_merge #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter type         meta_t       = logic [31:0],
    parameter type         rsp_t        = logic [7:0],
    parameter bit          DROP_ON_MISS = 1'b0,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ID_WIDTH-1:0]       rsp_id_i,
    input  logic [$bits(rsp_t)-1:0]   rsp_i,
    input  logic                      rsp_valid_i,
    output logic                      rsp_ready_o,
    output logic [ID_WIDTH-1:0]       q_id_o,
    output logic                      q_pop_o,
    output logic                      q_req_o,
    input  logic [$bits(meta_t)-1:0]  q_data_i,
    input  logic                      q_data_valid_i,
    input  logic                      q_gnt_i,
    output logic [ID_WIDTH-1:0]       mst_id_o,
    output logic [$bits(rsp_t)-1:0]   mst_rsp_o,
    output logic [$bits(meta_t)-1:0]  mst_meta_o,
    output logic                      mst_miss_o,
    output logic                      mst_valid_o,
    input  logic                      mst_ready_i,
    output logic [CNT_WIDTH-1:0]      miss_cnt_o
);

    localparam int unsigned RSP_W  = $bits(rsp_t);
    localparam int unsigned META_W = $bits(meta_t);

    // Raw vectors rather than rsp_t/meta_t fields, so that struct-typed
    // parameters do not need casts at the ports.
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [RSP_W-1:0]    rsp;
        logic [META_W-1:0]   meta;
        logic                miss;
    } entry_t;

    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic [1:0]           count_q, count_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic                 space_avail;
    logic                 lookup_fire;
    logic                 is_miss;
    logic                 do_write;
    logic                 do_drain;
    logic [1:0]           count_after_drain;
    entry_t               new_entry;

    // Handshake decode. A full buffer still accepts a response when the head
    // is leaving in the same cycle, which is what keeps one response per
    // cycle flowing under continuous grant and ready.
    always_comb begin
        do_drain    = (count_q != 2'd0) && mst_ready_i;
        space_avail = (count_q != 2'd2) || mst_ready_i;
        q_req_o     = rsp_valid_i && space_avail;
        lookup_fire = q_req_o && q_gnt_i;
        is_miss     = lookup_fire && !q_data_valid_i;
        // A dropped miss is still consumed upstream and still counted, but
        // it never occupies a buffer slot.
        do_write    = lookup_fire && !(DROP_ON_MISS && !q_data_valid_i);
    end

    // Merged record for the current lookup; metadata is forced to zero on a
    // miss because q_data_i carries no meaning then.
    always_comb begin
        new_entry.id   = rsp_id_i;
        new_entry.rsp  = rsp_i;
        new_entry.meta = q_data_valid_i ? q_data_i : '0;
        new_entry.miss = !q_data_valid_i;
    end

    // Buffer update. Draining shifts the tail into the head first; the new
    // record then lands in the first free slot left after that shift, so a
    // simultaneous capture and drain keeps the order intact.
    always_comb begin
        head_d            = head_q;
        tail_d            = tail_q;
        count_after_drain = count_q - {1'b0, do_drain};
        if (do_drain) begin
            head_d = tail_q;
        end
        if (do_write) begin
            if (count_after_drain == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
        end
        count_d = count_q + {1'b0, do_write} - {1'b0, do_drain};
    end

    // Miss counter sticks at all-ones instead of wrapping.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (is_miss && (miss_cnt_q != {CNT_WIDTH{1'b1}})) begin
            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            miss_cnt_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign rsp_ready_o = lookup_fire;
    assign q_id_o      = rsp_id_i;
    assign q_pop_o     = 1'b1;
    assign mst_valid_o = (count_q != 2'd0);
    assign mst_id_o    = head_q.id;
    assign mst_rsp_o   = head_q.rsp;
    assign mst_meta_o  = head_q.meta;
    assign mst_miss_o  = head_q.miss;
    assign miss_cnt_o  = miss_cnt_q;

`ifndef SYNTHESIS
    a_id_width : assert property (@(posedge clk_i) ID_WIDTH >= 1)
        else $error("id_queue_rsp_merge: ID_WIDTH must be >= 1");

    a_dv_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
        q_gnt_i |-> !$isunknown(q_data_valid_i))
        else $error("id_queue_rsp_merge: q_data_valid_i unknown while granted");

    a_rsp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_i && !rsp_ready_o) |=>
            (rsp_valid_i && $stable(rsp_id_i) && $stable(rsp_i)))
        else $error("id_queue_rsp_merge: upstream response changed while stalled");

    a_mst_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mst_valid_o && !mst_ready_i) |=>
            (mst_valid_o && $stable(mst_id_o) && $stable(mst_rsp_o) &&
             $stable(mst_meta_o) && $stable(mst_miss_o)))
        else $error("id_queue_rsp_merge: output changed while stalled");

    a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= 2'd2)
        else $error("id_queue_rsp_merge: buffer count above two");
`endif

endmodule

// File: doc/id_queue_rsp_merge.md
Name: id_queue_rsp_merge

Overview:
- Downstream consumer of the id_queue output port.
- Accepts a response stream tagged with an ID and looks up the oldest id_queue entry with that ID, popping it.
- Merges the stored metadata with the response and emits the result on a registered valid/ready stream.
- Sits in front of response demux/reorder logic, e.g. returning per-transaction metadata stored at request time.

Parameters:
- ID_WIDTH, 4, width of the response/queue ID (must be >= 1).
- meta_t, logic[31:0], type of the element stored in the id_queue.
- rsp_t, logic[7:0], type of the response payload passed through.
- DROP_ON_MISS, 0, 1: responses with no queue match are consumed and discarded; 0: they are forwarded with miss flag set.
- CNT_WIDTH, 16, width of the saturating miss counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rsp_id_i  in  ID_WIDTH  response ID
- rsp_i  in  $bits(rsp_t)  response payload
- rsp_valid_i  in  1  response valid
- rsp_ready_o  out  1  response accepted
- q_id_o  out  ID_WIDTH  lookup ID to id_queue oup port
- q_pop_o  out  1  pop request to id_queue, tied 1
- q_req_o  out  1  lookup request to id_queue
- q_data_i  in  $bits(meta_t)  looked-up element
- q_data_valid_i  in  1  element found, qualified by q_gnt_i
- q_gnt_i  in  1  lookup granted (data returned same cycle)
- mst_id_o  out  ID_WIDTH  merged ID
- mst_rsp_o  out  $bits(rsp_t)  merged response payload
- mst_meta_o  out  $bits(meta_t)  popped metadata, '0 on miss
- mst_miss_o  out  1  no queue entry existed for ID
- mst_valid_o  out  1  output valid
- mst_ready_i  in  1  output ready
- miss_cnt_o  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset: buffer empty, mst_valid_o=0, all mst_* data outputs '0, miss_cnt_o=0, rsp_ready_o=0, q_req_o=0.
- Storage: 2-entry FIFO buffer (count 0/1/2) of {id, rsp, meta, miss}; outputs driven directly from the head register (no combinational path rsp_* -> mst_*).
- Lookup:
  - q_req_o = rsp_valid_i && count<2, or count==2 && mst_ready_i (drain frees slot).
  - q_id_o = rsp_id_i; q_pop_o = 1.
- Handshake:
  - Lookup fires iff q_req_o && q_gnt_i; rsp_ready_o = that same condition (combinational from q_gnt_i).
  - If q_gnt_i=0, q_req_o stays asserted.
  - Upstream holds rsp_* stable while rsp_valid_i && !rsp_ready_o (AXI-style); the block never drops q_req_o while rsp_valid_i is high and space exists.
- Capture on fire:
  - q_data_valid_i=1: entry {rsp_id_i, rsp_i, q_data_i, miss=0}.
  - q_data_valid_i=0: miss; entry meta='0, miss=1.
  - DROP_ON_MISS=1 and miss: rsp_ready_o still 1, no entry written.
- Latency: response accepted in cycle N appears on mst_* in cycle N+1 (1-cycle registered).
- Throughput: 1 response/cycle sustained when q_gnt_i and mst_ready_i stay high.
- Drain: mst_valid_o = count>0; the head pops on mst_valid_o && mst_ready_i. Simultaneous capture+drain keeps count unchanged and ordering preserved. Count never exceeds 2.
- Miss counter:
  - Increments by 1 per miss fire, regardless of DROP_ON_MISS.
  - Saturates at 2^CNT_WIDTH-1; never wraps.
- Output stability: mst_* held stable while mst_valid_o && !mst_ready_i.
- Reset mid-operation: buffer contents discarded, counter cleared; pops already performed in the id_queue are not undone.
- Assertions (non-synthesis):
  - q_data_valid_i never X when q_gnt_i.
  - Stream stability on both interfaces.
  - ID_WIDTH >= 1.

Test Plan:
- Basic hit: queue holds id 3 meta 0xAAAA_0001; send rsp id 3 payload 0x5C, q_gnt_i=1, q_data_valid_i=1 -> next cycle mst_id_o=3, mst_rsp_o=0x5C, mst_meta_o=0xAAAA_0001, mst_miss_o=0, miss_cnt_o=0.
- Miss: rsp id 7 with q_data_valid_i=0, DROP_ON_MISS=0 -> mst_miss_o=1, mst_meta_o=0, miss_cnt_o=1. Same stimulus with DROP_ON_MISS=1 -> rsp_ready_o=1, no mst_valid_o, miss_cnt_o=1.
- Backpressure: mst_ready_i=0, three back-to-back rsps -> first two accepted (count=2), third sees q_req_o=0 and rsp_ready_o=0. Raise mst_ready_i -> outputs drain in order 1,2,3 with no loss or duplication.
- Grant stall: q_gnt_i=0 for 4 cycles with rsp_valid_i=1 -> q_req_o held 1 and q_id_o stable, rsp_ready_o=0. Output appears 1 cycle after the gnt cycle.
- Saturation: CNT_WIDTH=2, 5 misses -> miss_cnt_o sequence 1,2,3,3,3.
- Reset mid-op: buffer holding 2 entries, assert rst_ni low asynchronously -> mst_valid_o=0 and miss_cnt_o=0 immediately. After release, a new hit flows with 1-cycle latency.
